// File: rtl/cpu_pkg.sv
// Shared CPU widths and the writeback entry bundle.
// Ports: none (package).
package cpu_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int BE_W       = 2;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [BE_W-1:0]       be;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering coprocessor writeback results.
// Ports: clk, rst, push/din, pop/head, count, full, empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic [2:0] count,
  output logic      full,
  output logic      empty
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  wb_entry_t  mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign full  = (count == 3'(DEPTH));
  assign empty = (count == 3'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU first, buffered coprocessor second,
// plus a per-register scoreboard of outstanding coprocessor results.
// Ports: clk, rst, alu_*, cop_* handshake, issue_*, busy, rf_*, fifo_count.
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_wr_en,
  input  logic [REG_ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0]     alu_wr_data,
  input  logic [BE_W-1:0]       alu_be,
  input  logic                  cop_valid,
  output logic                  cop_ready,
  input  logic [REG_ADDR_W-1:0] cop_addr,
  input  logic [DATA_W-1:0]     cop_data,
  input  logic [BE_W-1:0]       cop_be,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  output logic [BE_W-1:0]       rf_be,
  output logic [2:0]            fifo_count
);

  wb_entry_t           din;
  wb_entry_t           head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] busy_d;

  // Full blocks a push even when a pop frees a slot this edge.
  assign cop_ready = ~rst & ~full;
  assign push      = cop_valid & cop_ready;
  assign pop       = ~alu_wr_en & ~empty;
  assign din       = '{addr: cop_addr, data: cop_data, be: cop_be};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Clear first so a same-edge issue wins.
  always_comb begin
    busy_d = busy;
    if (pop)      busy_d[head.addr]  = 1'b0;
    if (issue_en) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      rf_be      <= '0;
    end else begin
      busy <= busy_d;
      if (alu_wr_en) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= alu_wr_addr;
        rf_wr_data <= alu_wr_data;
        rf_be      <= alu_be;
      end else if (pop) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= head.addr;
        rf_wr_data <= head.data;
        rf_be      <= head.be;
      end else begin
        rf_wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
// Ports: none (top-level bench).
module tb_writeback_arbiter;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wr_en;
  logic [2:0]  alu_wr_addr;
  logic [15:0] alu_wr_data;
  logic [1:0]  alu_be;
  logic        cop_valid;
  logic        cop_ready;
  logic [2:0]  cop_addr;
  logic [15:0] cop_data;
  logic [1:0]  cop_be;
  logic        issue_en;
  logic [2:0]  issue_addr;
  logic [7:0]  busy;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [1:0]  rf_be;
  logic [2:0]  fifo_count;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_wr_en   (alu_wr_en),
    .alu_wr_addr (alu_wr_addr),
    .alu_wr_data (alu_wr_data),
    .alu_be      (alu_be),
    .cop_valid   (cop_valid),
    .cop_ready   (cop_ready),
    .cop_addr    (cop_addr),
    .cop_data    (cop_data),
    .cop_be      (cop_be),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_be       (rf_be),
    .fifo_count  (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic en, input logic [2:0] a,
                     input logic [15:0] d, input logic [1:0] b);
    alu_wr_en = en; alu_wr_addr = a; alu_wr_data = d; alu_be = b;
  endtask

  task automatic cop(input logic v, input logic [2:0] a,
                     input logic [15:0] d, input logic [1:0] b);
    cop_valid = v; cop_addr = a; cop_data = d; cop_be = b;
  endtask

  initial begin
    rst = 1'b1;
    alu(0, 0, 0, 0);
    cop(0, 0, 0, 0);
    issue_en = 0; issue_addr = 0;
    tick(); tick();
    chk("rst_en",    32'(rf_wr_en),   0);
    chk("rst_busy",  32'(busy),       0);
    chk("rst_cnt",   32'(fifo_count), 0);
    chk("rst_ready", 32'(cop_ready),  0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(cop_ready), 1);

    // ALU only
    alu(1, 3, 16'h1234, 2'b11);
    tick();
    alu(0, 0, 0, 0);
    chk("alu_en",   32'(rf_wr_en),   1);
    chk("alu_addr", 32'(rf_wr_addr), 3);
    chk("alu_data", 32'(rf_wr_data), 32'h1234);
    chk("alu_be",   32'(rf_be),      3);
    chk("alu_busy", 32'(busy),       0);
    tick();
    chk("idle_en",   32'(rf_wr_en),   0);
    chk("hold_addr", 32'(rf_wr_addr), 3);
    chk("hold_data", 32'(rf_wr_data), 32'h1234);

    // Coprocessor path, be=00 passes through
    issue_en = 1; issue_addr = 5;
    tick();
    issue_en = 0;
    chk("cp_busy1", 32'(busy), 32'h20);
    cop(1, 5, 16'hBEEF, 2'b00);
    tick();
    cop(0, 0, 0, 0);
    chk("cp_cnt1", 32'(fifo_count), 1);
    chk("cp_en0",  32'(rf_wr_en),   0);
    tick();
    chk("cp_en",   32'(rf_wr_en),   1);
    chk("cp_addr", 32'(rf_wr_addr), 5);
    chk("cp_data", 32'(rf_wr_data), 32'hBEEF);
    chk("cp_be",   32'(rf_be),      0);
    chk("cp_busy", 32'(busy),       0);
    chk("cp_cnt0", 32'(fifo_count), 0);

    // Contention: ALU edges 1-4, cop pushes edges 1-2
    alu(1, 1, 16'hA000, 2'b11);
    cop(1, 6, 16'h0001, 2'b11);
    tick();
    chk("ct_data1", 32'(rf_wr_data), 32'hA000);
    chk("ct_cnt1",  32'(fifo_count), 1);
    chk("ct_rdy1",  32'(cop_ready),  1);
    alu(1, 1, 16'hA001, 2'b11);
    cop(1, 7, 16'h0002, 2'b01);
    tick();
    cop(0, 0, 0, 0);
    chk("ct_cnt2", 32'(fifo_count), 2);
    chk("ct_rdy2", 32'(cop_ready),  0);
    alu(1, 1, 16'hA002, 2'b11);
    tick();
    alu(1, 1, 16'hA003, 2'b11);
    tick();
    chk("ct_data4", 32'(rf_wr_data), 32'hA003);
    chk("ct_cnt4",  32'(fifo_count), 2);
    chk("ct_rdy4",  32'(cop_ready),  0);
    alu(0, 0, 0, 0);
    tick();
    chk("ct_en5",   32'(rf_wr_en),   1);
    chk("ct_addr5", 32'(rf_wr_addr), 6);
    chk("ct_data5", 32'(rf_wr_data), 32'h0001);
    chk("ct_cnt5",  32'(fifo_count), 1);
    chk("ct_rdy5",  32'(cop_ready),  1);
    tick();
    chk("ct_addr6", 32'(rf_wr_addr), 7);
    chk("ct_data6", 32'(rf_wr_data), 32'h0002);
    chk("ct_be6",   32'(rf_be),      1);
    chk("ct_cnt6",  32'(fifo_count), 0);
    tick();
    chk("ct_en7", 32'(rf_wr_en), 0);

    // Full with pop: no pass-through while full
    alu(1, 0, 16'h0000, 2'b11);
    cop(1, 1, 16'h0011, 2'b11);
    tick();
    cop(1, 2, 16'h0022, 2'b11);
    tick();
    alu(0, 0, 0, 0);
    cop(1, 3, 16'h0033, 2'b11);
    #1;
    chk("fp_cnt2", 32'(fifo_count), 2);
    chk("fp_rdy0", 32'(cop_ready),  0);
    tick();
    chk("fp_data1", 32'(rf_wr_data), 32'h0011);
    chk("fp_cnt1",  32'(fifo_count), 1);
    chk("fp_rdy1",  32'(cop_ready),  1);
    tick();
    cop(0, 0, 0, 0);
    chk("fp_data2", 32'(rf_wr_data), 32'h0022);
    chk("fp_cnt1b", 32'(fifo_count), 1);
    tick();
    chk("fp_data3", 32'(rf_wr_data), 32'h0033);
    chk("fp_addr3", 32'(rf_wr_addr), 3);
    chk("fp_cnt0",  32'(fifo_count), 0);

    // Set/clear collision on r2
    issue_en = 1; issue_addr = 2;
    tick();
    issue_en = 0;
    chk("cc_busy1", 32'(busy), 32'h04);
    cop(1, 2, 16'h0055, 2'b10);
    tick();
    cop(0, 0, 0, 0);
    chk("cc_cnt", 32'(fifo_count), 1);
    issue_en = 1; issue_addr = 2;
    tick();
    issue_en = 0;
    chk("cc_addr", 32'(rf_wr_addr), 2);
    chk("cc_data", 32'(rf_wr_data), 32'h0055);
    chk("cc_busy", 32'(busy),       32'h04);

    // Reset mid-flight
    alu(1, 0, 16'h0000, 2'b11);
    cop(1, 2, 16'h00AA, 2'b11);
    issue_en = 1; issue_addr = 5;
    tick();
    issue_en = 0;
    cop(1, 5, 16'h00BB, 2'b11);
    tick();
    alu(0, 0, 0, 0);
    cop(0, 0, 0, 0);
    chk("rm_busy", 32'(busy),       32'h24);
    chk("rm_cnt",  32'(fifo_count), 2);
    rst = 1'b1;
    #1;
    chk("rm_en",    32'(rf_wr_en),   0);
    chk("rm_addr",  32'(rf_wr_addr), 0);
    chk("rm_data",  32'(rf_wr_data), 0);
    chk("rm_be",    32'(rf_be),      0);
    chk("rm_busy0", 32'(busy),       0);
    chk("rm_cnt0",  32'(fifo_count), 0);
    chk("rm_rdy0",  32'(cop_ready),  0);
    tick();
    rst = 1'b0;
    cop(1, 4, 16'h00CC, 2'b11);
    #1;
    chk("rr_rdy", 32'(cop_ready), 1);
    tick();
    cop(0, 0, 0, 0);
    chk("rr_en0", 32'(rf_wr_en),   0);
    chk("rr_cnt", 32'(fifo_count), 1);
    tick();
    chk("rr_en",   32'(rf_wr_en),   1);
    chk("rr_data", 32'(rf_wr_data), 32'h00CC);
    chk("rr_addr", 32'(rf_wr_addr), 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, giving the coprocessor result buffer depth (legal 2..4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have ports alu_wr_en/alu_wr_addr/alu_wr_data/alu_be, input, 1/3/16/2, the single-cycle pipeline writeback request.
REQ-005 The block SHALL have ports cop_valid (in 1), cop_ready (out 1), cop_addr (in 3), cop_data (in 16), cop_be (in 2), the FPU/crypto result handshake.
REQ-006 The block SHALL have ports issue_en/issue_addr, input, 1/3, marking a coprocessor op issued to a destination register.
REQ-007 The block SHALL have port busy, output, 8, the per-register pending-coprocessor-result scoreboard.
REQ-008 The block SHALL have ports rf_wr_en/rf_wr_addr/rf_wr_data/rf_be, output, 1/3/16/2, driving the register file write port.
REQ-009 The block SHALL have port fifo_count, output, 3, the current buffer occupancy.

Function
REQ-010 rf_* outputs SHALL be registered; each cycle drives at most one write.
REQ-011 Priority at each edge SHALL be: alu_wr_en=1 loads ALU request into rf_*; else fifo_count>0 pops the head into rf_*; else rf_wr_en<=0.
REQ-012 ALU latency SHALL be 1 edge: request at edge N appears on rf_* in cycle after N.
REQ-013 cop_ready SHALL be combinational: 1 iff fifo_count<FIFO_DEPTH and rst=0; no pass-through when full, even with simultaneous pop.
REQ-014 A transfer SHALL occur on an edge with cop_valid&cop_ready; entry {addr,data,be} pushed at tail.
REQ-015 Minimum coprocessor latency SHALL be 2 edges (push at N, pop at N+1, rf_wr_en high after N+1).
REQ-016 Push and pop on the same edge SHALL leave fifo_count unchanged; FIFO order strictly preserved; pointers wrap modulo FIFO_DEPTH.
REQ-017 ALU traffic every cycle SHALL starve the FIFO indefinitely; no fairness counter (decode guarantees gaps).
REQ-018 rf_be and rf_wr_data SHALL pass unmodified, including be=2'b00.
REQ-019 busy[issue_addr] SHALL set on an edge with issue_en=1.
REQ-020 busy[a] SHALL clear on the edge a FIFO entry with addr=a is popped into rf_*.
REQ-021 Simultaneous set and clear of the same bit SHALL resolve to set.
REQ-022 issue_en to an already-busy register SHALL leave it set; ALU writes SHALL never change busy.
REQ-023 rf_* SHALL hold last addr/data when rf_wr_en=0 (only rf_wr_en is meaningful).

Reset
REQ-024 rst=1 SHALL immediately force rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rf_be=0, busy=0, fifo_count=0, cop_ready=0.
REQ-025 Reset mid-operation SHALL discard buffered entries and pending busy bits without issuing writes.
REQ-026 First edge after rst deassertion SHALL see cop_ready=1 and accept transfers normally.

Structure
REQ-027 Shared package cpu_pkg SHALL hold DATA_W=16, REG_ADDR_W=3, BE_W=2, NUM_REGS=8 and the writeback entry struct {addr,data,be}.
REQ-028 The buffer SHALL be a sub-module wb_fifo (synchronous FIFO, push/pop/count/full/empty); arbitration and scoreboard stay in writeback_arbiter.

Verification
REQ-029 ALU only: alu_wr_en=1, addr=3, data=16'h1234, be=2'b11 at edge 1 -> rf_wr_en=1, rf_wr_addr=3, rf_wr_data=16'h1234 after edge 1; busy=0.
REQ-030 Coprocessor path: issue_en addr=5 at edge 1; cop_valid addr=5 data=16'hBEEF at edge 2 -> busy[5]=1 after edge 1, rf write of 16'hBEEF to r5 after edge 3, busy[5]=0 after edge 3.
REQ-031 Contention: ALU writes edges 1-4, cop pushes 16'h0001, 16'h0002 at edges 1-2 -> cop_ready=0 from edge 2 to 5, FIFO entries written in order after edges 5 and 6, fifo_count returns 0.
REQ-032 Full-with-pop: FIFO full, ALU idle, cop_valid held -> cop_ready=0 that cycle, next cycle cop_ready=1, count never exceeds 2.
REQ-033 Set/clear collision: pop entry for r2 and issue_en addr=2 same edge -> busy[2]=1 afterwards.
REQ-034 Reset mid-flight: rst asserted with count=2, busy=8'h24 -> outputs zero immediately, no rf write after release, cop_ready=1 after release.
